spi_host_word_shifter: RTL
==========================

// Module: spi_host_word_shifter
// PURPOSE
//  Parametrised successor of the SPI host byte shift register. Between the command FSM and the
//  tx/rx word merge logic. Shifts words of 1..WordWidth/8 bytes over 1/2/4/8 lanes, MSB- or
//  LSB-first. Counts shifts per word. Queues received words in a RxDepth-entry buffer.
// PARAMETERS
//  Lanes      8   physical data lanes; legal values 4 or 8 (Octal needs 8)
//  WordWidth  32  max word length in bits; multiple of 8, >= 8
//  RxDepth    2   rx buffer entries; >= 1
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          synchronous reset, active-high
//  sw_rst_i     in   1          software reset; same effect as rst_i, one-cycle pulse
//  speed_i      in   2          speed_e: Standard / Dual / Quad / Octal
//  lsb_first_i  in   1          1: shift LSB-first
//  word_bytes_i in   WBW        word length minus one, in bytes; WBW=max(1,$clog2(WordWidth/8))
//  wr_en_i      in   1          FSM request: load the next tx word
//  wr_ready_o   out  1          tx word available (= tx_valid_i)
//  rd_en_i      in   1          FSM request: commit the rx word (with the current shift)
//  rd_ready_o   out  1          rx buffer can accept a word this cycle
//  shift_en_i   in   1          shift one beat
//  sample_en_i  in   1          register sd_i for a half-cycle sample
//  full_cyc_i   in   1          1: shift uses live sd_i; 0: shift uses sampled sd_i
//  cmd_end_i    in   1          current word is the last of the command
//  tx_data_i    in   WordWidth  tx word; the low N bits are valid, N=(word_bytes+1)*8
//  tx_valid_i   in   1          tx word valid
//  tx_ready_o   out  1          tx word consumed (= wr_en_i)
//  tx_flush_o   out  1          = cmd_end_i
//  rx_data_o    out  WordWidth  head rx word; zero-extended above N
//  rx_valid_o   out  1          rx buffer not empty
//  rx_ready_i   in   1          consumer accepts the head word
//  rx_last_o    out  1          cmd_end_i captured with the head word
//  word_done_o  out  1          one-cycle pulse on the final shift of a word
//  sd_i         in   Lanes      serial data in
//  sd_o         out  Lanes      serial data out; lanes not used at the current speed drive 0
// BEHAVIOUR
//  - Reset (rst_i or sw_rst_i): zeroes the shift register, sampled sd_i, config, shift counter
//    and rx buffer. sw_rst_i has priority over every other input.
//  - All outputs after reset are 0, except wr_ready_o/tx_ready_o/tx_flush_o, which are
//    combinational pass-throughs. rd_ready_o=1.
//  - Load: wr_en_i & tx_valid_i => sr<=tx_data_i and cnt<=0; speed_i, lsb_first_i and
//    word_bytes_i are latched into cfg. All shifting and rx use cfg, never the live inputs.
//  - k = lanes for cfg.speed (1/2/4/8). Beats per word B = N/k.
//  - MSB-first: sd_o[k-1:0]=sr[N-1 -: k]. A shift moves sr left by k and inserts next_bits[k-1:0]
//    at bit 0.
//  - LSB-first: sd_o[k-1:0]=sr[k-1:0]. A shift moves sr right by k and inserts next_bits[k-1:0]
//    at bits N-1..N-k. Bits at N and above stay 0.
//  - next_bits = full_cyc_i ? sd_i : sd_i_q. sd_i_q <= sd_i when sample_en_i.
//  - Shift counter: on shift_en_i, cnt increments. If cnt==B-1: word_done_o=1 (same cycle,
//    combinational) and cnt wraps to 0.
//  - Simultaneous load and shift: the load wins.
//  - Rx: rd_en_i & rd_ready_o pushes {cmd_end_i, shifted value, masked to N bits}. This captures
//    the final beat in the same cycle as it shifts.
//  - Pop on rx_valid_o & rx_ready_i.
//  - rd_ready_o = ~full | (rx_valid_o & rx_ready_i). Push and pop on a full buffer is legal;
//    occupancy is unchanged.
//  - rd_en_i while ~rd_ready_o: the word is dropped; the FSM must stall instead. Asserted.
//  - cfg.speed==Octal with Lanes==4: illegal. Asserted at the load handshake.
//  - word_bytes_i > WordWidth/8-1: illegal. Asserted.
//  - Reset mid-word: the partial word is discarded; no rx push occurs.
// STRUCTURE
//  - spi_host_word_pkg: speed_e (Standard=0, Dual=1, Quad=2, Octal=3), function lanes_of(speed_e),
//    typedef cfg_t {speed, lsb_first, word_bytes}.
//  - Sub-module spi_host_word_rxbuf: sync-reset circular FIFO. RxDepth x (WordWidth+1); provides
//    full/empty and same-cycle push/pop.
// TESTING
//  1. Std MSB 1B: load 8'hA5; 8 shifts, sd_i[0]=1,0,1,1,0,0,1,0 -> sd_o[0]=1,0,1,0,0,1,0,1;
//     word_done_o on the 8th shift; push rx_data 8'hB2.
//  2. Quad LSB 4B: load 32'h1234_5678, 8 shifts -> sd_o[3:0]=8,7,6,5,4,3,2,1. Loop sd_o->sd_i
//     full_cyc -> rx 32'h1234_5678.
//  3. Octal MSB 2B with full_cyc_i=0: sample 8'h3C then shift; sample 8'h81 then shift -> rx 16'h3C81;
//     word_done_o on beat 2.
//  4. RxDepth=2: push 3 words, rx_ready_i=0 -> rd_ready_o=0 after 2. Then pop and push in the
//     same cycle -> occupancy stays 2; order is preserved; rx_last_o follows cmd_end_i.
//  5. Change speed_i mid-word (Dual -> Quad after beat 1) -> the word still completes at Dual;
//     the next load uses Quad.
//  6. sw_rst_i at beat 3 of a 4B word with 1 rx entry queued -> next cycle rx_valid_o=0,
//     sd_o=0, cnt=0; no word_done_o.

Source files
------------

// File: rtl/spi_host_word_pkg.sv
// Shared types for the SPI host word shifter.
//   speed_e  : lane configuration of a word (Standard/Dual/Quad/Octal)
//   cfg_t    : per-word configuration latched at the load handshake
//   lanes_of : number of active data lanes for a speed
package spi_host_word_pkg;

  typedef enum logic [1:0] {
    Standard = 2'd0,
    Dual     = 2'd1,
    Quad     = 2'd2,
    Octal    = 2'd3
  } speed_e;

  // Holds word_bytes for any WordWidth up to 2048 bits.
  localparam int CfgWbw = 8;

  typedef struct packed {
    speed_e              speed;
    logic                lsb_first;
    logic [CfgWbw-1:0]   word_bytes;
  } cfg_t;

  function automatic logic [3:0] lanes_of(speed_e speed);
    case (speed)
      Standard: lanes_of = 4'd1;
      Dual:     lanes_of = 4'd2;
      Quad:     lanes_of = 4'd4;
      Octal:    lanes_of = 4'd8;
      default:  lanes_of = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/spi_host_word_rxbuf.sv
// Circular FIFO holding received words until the consumer takes them.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears occupancy)
//   push, push_data write one entry (ignored when full unless popping this cycle)
//   pop             remove the head entry (ignored when empty)
//   full, empty     occupancy flags
//   head            oldest entry; undefined while empty
module spi_host_word_rxbuf #(
  parameter int Depth = 2,
  parameter int Width = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push, do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer may still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PtrW-1:0] bump(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; occupancy is, and the head is
  // masked downstream while empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_host_word_shifter.sv
// SPI host word shift register: shifts 1..WordWidth/8-byte words over
// 1/2/4/8 lanes, MSB- or LSB-first, counts beats per word and queues
// received words in a small rx buffer.
// Ports:
//   clk_i, rst_i, sw_rst_i   clock, synchronous reset, software reset pulse
//   speed_i, lsb_first_i,    word configuration, latched at load
//   word_bytes_i
//   wr_en_i / wr_ready_o     FSM load request / tx word available
//   rd_en_i / rd_ready_o     FSM rx commit request / rx buffer can accept
//   shift_en_i, sample_en_i, beat controls; full_cyc_i selects live or
//   full_cyc_i, cmd_end_i    sampled sd_i; cmd_end_i marks the last word
//   tx_data_i, tx_valid_i,   tx word stream
//   tx_ready_o, tx_flush_o
//   rx_data_o, rx_valid_o,   rx word stream (head of the rx buffer)
//   rx_ready_i, rx_last_o
//   word_done_o              pulse on the final beat of a word
//   sd_i, sd_o               serial data lanes
module spi_host_word_shifter
  import spi_host_word_pkg::*;
#(
  parameter int Lanes     = 8,
  parameter int WordWidth = 32,
  parameter int RxDepth   = 2,
  localparam int Wbw      = (WordWidth / 8 > 1) ? $clog2(WordWidth / 8) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sw_rst_i,
  input  speed_e               speed_i,
  input  logic                 lsb_first_i,
  input  logic [Wbw-1:0]       word_bytes_i,
  input  logic                 wr_en_i,
  output logic                 wr_ready_o,
  input  logic                 rd_en_i,
  output logic                 rd_ready_o,
  input  logic                 shift_en_i,
  input  logic                 sample_en_i,
  input  logic                 full_cyc_i,
  input  logic                 cmd_end_i,
  input  logic [WordWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_flush_o,
  output logic [WordWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_last_o,
  output logic                 word_done_o,
  input  logic [Lanes-1:0]     sd_i,
  output logic [Lanes-1:0]     sd_o
);

  localparam int NW = $clog2(WordWidth) + 1;

  cfg_t                 cfg_q;
  logic [WordWidth-1:0] sr_q, sr_shift, word_mask, rx_word;
  logic [Lanes-1:0]     sd_i_q, lane_mask, next_bits;
  logic [NW-1:0]        cnt_q, n_bits, k_bits, beats;
  logic                 reset, load, last_beat, push, pop, full, empty;
  logic [WordWidth:0]   head;

  // Bits below N set. When N==WordWidth the shift wraps to 0 and the
  // subtraction yields all ones.
  function automatic logic [WordWidth-1:0] mask_of(logic [CfgWbw-1:0] wb);
    logic [NW-1:0] n;
    n = NW'((32'(wb) + 32'd1) * 32'd8);
    return (WordWidth'(1) << n) - WordWidth'(1);
  endfunction

  assign reset      = rst_i | sw_rst_i;
  assign load       = wr_en_i & tx_valid_i;
  assign wr_ready_o = tx_valid_i;
  assign tx_ready_o = wr_en_i;
  assign tx_flush_o = cmd_end_i;

  // Word geometry comes from the latched config only.
  assign n_bits    = NW'((32'(cfg_q.word_bytes) + 32'd1) * 32'd8);
  assign k_bits    = NW'(lanes_of(cfg_q.speed));
  assign beats     = n_bits >> cfg_q.speed;  // k is 2**speed
  assign lane_mask = Lanes'((32'd1 << lanes_of(cfg_q.speed)) - 32'd1);
  assign word_mask = mask_of(cfg_q.word_bytes);
  assign last_beat = (cnt_q == beats - NW'(1));
  assign next_bits = (full_cyc_i ? sd_i : sd_i_q) & lane_mask;

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sd_o     = sr_q[Lanes-1:0] & lane_mask;
    sr_shift = (sr_q >> k_bits) | (WordWidth'(next_bits) << (n_bits - k_bits));
    if (!cfg_q.lsb_first) begin
      sd_o     = Lanes'(sr_q >> (n_bits - k_bits)) & lane_mask;
      sr_shift = ((sr_q << k_bits) | WordWidth'(next_bits)) & word_mask;
    end
  end

  // A load in the same cycle as a shift takes precedence, so no beat completes.
  assign word_done_o = shift_en_i & ~load & ~reset & last_beat;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      sr_q   <= '0;
      sd_i_q <= '0;
      cfg_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (sample_en_i) sd_i_q <= sd_i;
      if (load) begin
        sr_q  <= tx_data_i & mask_of(CfgWbw'(word_bytes_i));
        cnt_q <= '0;
        cfg_q <= '{speed: speed_i, lsb_first: lsb_first_i,
                   word_bytes: CfgWbw'(word_bytes_i)};
      end else if (shift_en_i) begin
        sr_q  <= sr_shift;
        cnt_q <= last_beat ? '0 : cnt_q + NW'(1);
      end
    end
  end

  // Commit captures the beat being shifted this cycle.
  assign rx_word    = (shift_en_i ? sr_shift : sr_q) & word_mask;
  assign pop        = rx_valid_o & rx_ready_i;
  assign rd_ready_o = ~full | pop;
  assign push       = rd_en_i & rd_ready_o & ~reset;

  spi_host_word_rxbuf #(
    .Depth (RxDepth),
    .Width (WordWidth + 1)
  ) u_rxbuf (
    .clk       (clk_i),
    .rst       (reset),
    .push      (push),
    .push_data ({cmd_end_i, rx_word}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign rx_valid_o = ~empty;
  assign rx_data_o  = empty ? '0 : head[WordWidth-1:0];
  assign rx_last_o  = ~empty & head[WordWidth];

  a_rd_stall: assert property (@(posedge clk_i) disable iff (reset)
    rd_en_i |-> rd_ready_o);
  a_octal_lanes: assert property (@(posedge clk_i) disable iff (reset)
    load |-> !(Lanes == 4 && speed_i == Octal));
  a_word_bytes: assert property (@(posedge clk_i) disable iff (reset)
    32'(word_bytes_i) <= WordWidth / 8 - 1);

endmodule
